// File: rtl/mat_tile_reader.sv
`timescale 1ns/1ps
// mat_tile_reader
//
// Reads one row of 16x16-byte tiles from a BRAM manager read port and hands
// them downstream one at a time through a valid/ready register stage.
// A request (line, last column) is accepted only while idle. Columns
// 0..last are fetched in order. Each fetch holds ENA/line/column steady
// until the memory answers with I_VLD. The captured tile is then held until
// downstream accepts it. The next column is fetched one cycle after the
// accept. A fetch left unanswered for 15 cycles aborts the row with an
// O_ERR pulse.
//
// Ports
//   I_CLK, I_RST_N        clock (rising edge), asynchronous active-low reset
//   I_START               row request, sampled only while idle
//   I_LINE, I_LAST_COL    row parameters, latched on an accepted request
//   O_ENA                 read enable toward the memory (read-only port)
//   O_SEL_LINE, O_SEL_COL line / column select toward the memory
//   I_VLD, I_MAT          memory answer strobe and tile data
//   O_TILE, O_TILE_COL    registered tile and its column index
//   O_TILE_VLD            O_TILE holds a tile not yet accepted
//   I_TILE_RDY            downstream accept
//   O_BUSY                high whenever a row is in progress
//   O_DONE                one-cycle pulse after the last tile is accepted
//   O_ERR                 one-cycle pulse when a fetch times out
module mat_tile_reader (
  input  logic                   I_CLK,
  input  logic                   I_RST_N,
  input  logic                   I_START,
  input  logic [5:0]             I_LINE,
  input  logic [2:0]             I_LAST_COL,
  output logic                   O_ENA,
  output logic [5:0]             O_SEL_LINE,
  output logic [2:0]             O_SEL_COL,
  input  logic                   I_VLD,
  input  logic [15:0][15:0][7:0] I_MAT,
  output logic [15:0][15:0][7:0] O_TILE,
  output logic                   O_TILE_VLD,
  input  logic                   I_TILE_RDY,
  output logic [2:0]             O_TILE_COL,
  output logic                   O_BUSY,
  output logic                   O_DONE,
  output logic                   O_ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] line_q;
  logic [2:0] last_q;
  logic [2:0] col_q;
  logic [3:0] wait_q;
  logic       err_q;

  logic [3:0] wait_inc;
  logic       timeout;
  logic       last_tile;

  // The wait counter counts fetch cycles that passed without an answer.
  // The fetch is abandoned on the edge that would bring the count to 15.
  // So a silent memory sees exactly 15 cycles of ENA.
  assign wait_inc  = wait_q + 4'd1;
  assign timeout   = (state == S_REQ) && !I_VLD && (wait_inc == 4'd15);
  assign last_tile = (col_q == last_q);

  // State register.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // I_VLD only matters while a fetch is outstanding.
  // I_TILE_RDY only matters while a tile is held.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (I_START) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (I_VLD) begin
          state_nxt = S_HOLD;
        end else if (timeout) begin
          state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (I_TILE_RDY) begin
          state_nxt = last_tile ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath registers.
  // Row parameters are written only from idle, so a late I_START cannot
  // disturb a row in progress.
  // The column counter advances only after a non-last accept, so it never
  // wraps.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      line_q     <= '0;
      last_q     <= '0;
      col_q      <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
      O_TILE     <= '0;
      O_TILE_COL <= '0;
      O_TILE_VLD <= 1'b0;
    end else begin
      err_q <= timeout;
      case (state)
        S_IDLE: begin
          if (I_START) begin
            line_q <= I_LINE;
            last_q <= I_LAST_COL;
            col_q  <= '0;
            wait_q <= '0;
          end
        end
        S_REQ: begin
          if (I_VLD) begin
            O_TILE     <= I_MAT;
            O_TILE_COL <= col_q;
            O_TILE_VLD <= 1'b1;
          end else if (timeout) begin
            O_TILE_VLD <= 1'b0;
          end else begin
            wait_q <= wait_inc;
          end
        end
        S_HOLD: begin
          if (I_TILE_RDY) begin
            O_TILE_VLD <= 1'b0;
            if (!last_tile) begin
              col_q  <= col_q + 3'd1;
              wait_q <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign O_ENA      = (state == S_REQ);
  assign O_SEL_LINE = line_q;
  assign O_SEL_COL  = col_q;
  assign O_BUSY     = (state != S_IDLE);
  assign O_DONE     = (state == S_DONE);
  assign O_ERR      = err_q;

endmodule

// File: tb/tb_mat_tile_reader.sv
`timescale 1ns/1ps
// tb_mat_tile_reader
//
// Self-checking bench for mat_tile_reader.
// A reactive memory model answers fetches with a random latency.
// It can also stay silent, and it can raise stray strobes while no fetch is
// open.
// Downstream ready is random, and stray start requests arrive while busy.
// A row-level reference model predicts every output each cycle.
// Directed scenarios pin exact tile counts, data, column order and pulses.
module tb_mat_tile_reader;

  logic                   I_CLK      = 1'b0;
  logic                   I_RST_N    = 1'b1;
  logic                   I_START    = 1'b0;
  logic [5:0]             I_LINE     = '0;
  logic [2:0]             I_LAST_COL = '0;
  logic                   I_VLD      = 1'b0;
  logic [15:0][15:0][7:0] I_MAT      = '0;
  logic                   I_TILE_RDY = 1'b0;
  logic                   O_ENA;
  logic [5:0]             O_SEL_LINE;
  logic [2:0]             O_SEL_COL;
  logic [15:0][15:0][7:0] O_TILE;
  logic                   O_TILE_VLD;
  logic [2:0]             O_TILE_COL;
  logic                   O_BUSY;
  logic                   O_DONE;
  logic                   O_ERR;

  mat_tile_reader dut (
    .I_CLK      (I_CLK),
    .I_RST_N    (I_RST_N),
    .I_START    (I_START),
    .I_LINE     (I_LINE),
    .I_LAST_COL (I_LAST_COL),
    .O_ENA      (O_ENA),
    .O_SEL_LINE (O_SEL_LINE),
    .O_SEL_COL  (O_SEL_COL),
    .I_VLD      (I_VLD),
    .I_MAT      (I_MAT),
    .O_TILE     (O_TILE),
    .O_TILE_VLD (O_TILE_VLD),
    .I_TILE_RDY (I_TILE_RDY),
    .O_TILE_COL (O_TILE_COL),
    .O_BUSY     (O_BUSY),
    .O_DONE     (O_DONE),
    .O_ERR      (O_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  int checks   = 0;
  int failures = 0;
  bit checking_on = 1'b0;

  // Stimulus configuration.
  int rdy_pct       = 100;
  int fixed_lat     = -1;
  bit fixed_pattern = 1'b0;
  bit mem_silent    = 1'b0;
  bit spurious      = 1'b0;
  int junk_pct      = 0;
  int req_age       = 0;
  int cur_lat       = 0;
  int resp_idx      = 0;

  // Reference model: row phase, row parameters, and the tile register
  // contents that must be visible downstream.
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_HOLD = 2;
  localparam int P_DONE = 3;
  int                     m_phase = P_IDLE;
  int                     m_wait  = 0;
  logic [5:0]             m_line  = '0;
  logic [2:0]             m_last  = '0;
  logic [2:0]             m_col   = '0;
  logic [2:0]             m_tcol  = '0;
  logic [15:0][15:0][7:0] m_tile  = '0;
  logic                   m_tvld  = 1'b0;
  logic                   m_err   = 1'b0;

  // Observation logs for the directed scenarios.
  logic [7:0] acc_byte[$];
  logic [2:0] acc_col[$];
  logic [2:0] sel_log[$];
  int         done_cnt   = 0;
  int         err_cnt    = 0;
  int         ena_cycles = 0;
  logic       prev_ena   = 1'b0;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkTile(input string name, input logic [15:0][15:0][7:0] exp);
    checks++;
    if (O_TILE !== exp) begin
      failures++;
      $display("[TB] FAIL %s row0 actual=%h expected=%h t=%0t", name, O_TILE[0], exp[0], $time);
    end
  endtask

  task automatic modelReset();
    m_phase = P_IDLE;
    m_wait  = 0;
    m_line  = '0;
    m_last  = '0;
    m_col   = '0;
    m_tcol  = '0;
    m_tile  = '0;
    m_tvld  = 1'b0;
    m_err   = 1'b0;
  endtask

  // Advances the model by one rising edge, using the inputs that the DUT
  // samples on that same edge.
  task automatic modelStep();
    if (!I_RST_N) begin
      modelReset();
      return;
    end
    m_err = 1'b0;
    case (m_phase)
      P_IDLE: begin
        if (I_START) begin
          m_line  = I_LINE;
          m_last  = I_LAST_COL;
          m_col   = '0;
          m_wait  = 0;
          m_phase = P_REQ;
        end
      end
      P_REQ: begin
        if (I_VLD) begin
          m_tile  = I_MAT;
          m_tcol  = m_col;
          m_tvld  = 1'b1;
          m_phase = P_HOLD;
        end else begin
          m_wait++;
          if (m_wait == 15) begin
            m_err   = 1'b1;
            m_tvld  = 1'b0;
            m_phase = P_IDLE;
          end
        end
      end
      P_HOLD: begin
        if (I_TILE_RDY) begin
          m_tvld = 1'b0;
          if (m_col == m_last) begin
            m_phase = P_DONE;
          end else begin
            m_col   = m_col + 3'd1;
            m_wait  = 0;
            m_phase = P_REQ;
          end
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic fillTile();
    logic [7:0] pat;
    pat = 8'h55 + 8'(resp_idx * 17);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        I_MAT[r][c] = fixed_pattern ? pat : 8'($urandom);
      end
    end
  endtask

  // Drives inputs just after a rising edge.
  // The memory answers an open fetch after the chosen latency. Stray
  // strobes and start requests are injected when configured.
  task automatic applyStimulus();
    I_START    = 1'b0;
    I_TILE_RDY = (int'($urandom_range(99, 0)) < rdy_pct);
    if (O_ENA) begin
      req_age++;
      if (!mem_silent && req_age > cur_lat) begin
        I_VLD = 1'b1;
        fillTile();
        resp_idx++;
      end else begin
        I_VLD = 1'b0;
      end
    end else begin
      req_age = 0;
      cur_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3, 0));
      I_VLD   = spurious && ($urandom_range(3, 0) == 0);
      if (I_VLD) begin
        for (int r = 0; r < 16; r++) begin
          for (int c = 0; c < 16; c++) begin
            I_MAT[r][c] = 8'($urandom);
          end
        end
      end
    end
    if (junk_pct > 0 && O_BUSY && int'($urandom_range(99, 0)) < junk_pct) begin
      I_START    = 1'b1;
      I_LINE     = 6'($urandom);
      I_LAST_COL = 3'($urandom);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  task automatic checkOutput();
    if (!checking_on) return;
    checkVal("ena",      O_ENA,      m_phase == P_REQ);
    checkVal("busy",     O_BUSY,     m_phase != P_IDLE);
    checkVal("done",     O_DONE,     m_phase == P_DONE);
    checkVal("err",      O_ERR,      m_err);
    checkVal("tile_vld", O_TILE_VLD, m_tvld);
    checkVal("tile_col", O_TILE_COL, m_tcol);
    checkTile("tile", m_tile);
    if (m_phase == P_REQ) begin
      checkVal("sel_line", O_SEL_LINE, m_line);
      checkVal("sel_col",  O_SEL_COL,  m_col);
    end
    if (O_TILE_VLD && I_TILE_RDY) begin
      acc_byte.push_back(O_TILE[0][0]);
      acc_col.push_back(O_TILE_COL);
    end
    if (O_DONE) done_cnt++;
    if (O_ERR) err_cnt++;
    if (O_ENA) ena_cycles++;
    if (O_ENA && !prev_ena) sel_log.push_back(O_SEL_COL);
    prev_ena = O_ENA;
  endtask

  task automatic tick();
    @(posedge I_CLK);
    modelStep();
    #1;
    applyStimulus();
    @(negedge I_CLK);
    checkOutput();
  endtask

  task automatic clearLogs();
    acc_byte.delete();
    acc_col.delete();
    sel_log.delete();
    done_cnt   = 0;
    err_cnt    = 0;
    ena_cycles = 0;
    resp_idx   = 0;
  endtask

  task automatic startRead(input logic [5:0] line, input logic [2:0] last);
    tick();
    I_START    = 1'b1;
    I_LINE     = line;
    I_LAST_COL = last;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    tick();
    while (O_BUSY && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (O_BUSY) begin
      failures++;
      $display("[TB] FAIL wait_idle actual=busy required=idle within %0d cycles", budget);
    end
  endtask

  task automatic waitTileVld(input int budget);
    int n;
    n = 0;
    while (!O_TILE_VLD && n < budget) begin
      tick();
      n++;
    end
    checkVal("wait_tile_vld", O_TILE_VLD, 1'b1);
  endtask

  // Asserts reset between clock edges.
  // Every output must already be cleared one time unit later.
  task automatic assertReset();
    #2;
    I_RST_N = 1'b0;
    modelReset();
    checking_on = 1'b1;
    #1;
    checkVal("rst_ena",      O_ENA,      1'b0);
    checkVal("rst_sel_line", O_SEL_LINE, 6'd0);
    checkVal("rst_sel_col",  O_SEL_COL,  3'd0);
    checkVal("rst_tile_vld", O_TILE_VLD, 1'b0);
    checkVal("rst_tile_col", O_TILE_COL, 3'd0);
    checkVal("rst_busy",     O_BUSY,     1'b0);
    checkVal("rst_done",     O_DONE,     1'b0);
    checkVal("rst_err",      O_ERR,      1'b0);
    checkTile("rst_tile", '0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the bench finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] mat_tile_reader bench starting");
    assertReset();
    tick();
    tick();
    I_RST_N = 1'b1;

    // Four-tile row with fixed data, ready always high.
    rdy_pct = 100;
    fixed_lat = 1;
    fixed_pattern = 1'b1;
    clearLogs();
    startRead(6'd2, 3'd3);
    waitIdle(200);
    tick();
    checkVal("row4_tiles", acc_byte.size(), 4);
    for (int i = 0; i < acc_byte.size(); i++) begin
      checkVal("row4_byte", acc_byte[i], 8'h55 + 8'h11 * i);
      checkVal("row4_col", acc_col[i], i);
    end
    checkVal("row4_fetches", sel_log.size(), 4);
    for (int i = 0; i < sel_log.size(); i++) begin
      checkVal("row4_sel_col", sel_log[i], i);
    end
    checkVal("row4_done", done_cnt, 1);
    checkVal("row4_err", err_cnt, 0);
    fixed_pattern = 1'b0;

    // Downstream stalls for 5 cycles with a stray start (line 9) mid-hold.
    fixed_lat = 0;
    rdy_pct = 0;
    clearLogs();
    startRead(6'd2, 3'd2);
    tick();
    waitTileVld(20);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) begin
        I_START    = 1'b1;
        I_LINE     = 6'd9;
        I_LAST_COL = 3'd7;
      end
    end
    checkVal("stall_ena", O_ENA, 1'b0);
    checkVal("stall_vld", O_TILE_VLD, 1'b1);
    checkVal("stall_col", O_TILE_COL, 3'd0);
    rdy_pct = 100;
    tick();
    tick();
    checkVal("stall_refetch", O_ENA, 1'b1);
    checkVal("stall_line_kept", O_SEL_LINE, 6'd2);
    waitIdle(200);
    tick();
    checkVal("stall_tiles", acc_byte.size(), 3);
    checkVal("stall_done", done_cnt, 1);

    // Memory never answers: exactly 15 fetch cycles, then an error pulse.
    mem_silent = 1'b1;
    clearLogs();
    startRead(6'd5, 3'd4);
    waitIdle(100);
    tick();
    checkVal("tmo_ena_cycles", ena_cycles, 15);
    checkVal("tmo_err", err_cnt, 1);
    checkVal("tmo_done", done_cnt, 0);
    checkVal("tmo_tiles", acc_byte.size(), 0);
    checkVal("tmo_tile_vld", O_TILE_VLD, 1'b0);
    mem_silent = 1'b0;

    // Reset during the column-1 fetch, then a one-tile row right after release.
    fixed_lat = 2;
    clearLogs();
    startRead(6'd4, 3'd3);
    begin
      int n;
      n = 0;
      while (!(O_ENA && O_SEL_COL == 3'd1) && n < 50) begin
        tick();
        n++;
      end
    end
    checkVal("mid_reset_reached_col1", O_SEL_COL, 3'd1);
    assertReset();
    tick();
    tick();
    clearLogs();
    I_RST_N    = 1'b1;
    I_START    = 1'b1;
    I_LINE     = 6'd1;
    I_LAST_COL = 3'd0;
    tick();
    checkVal("first_start_after_reset", O_BUSY, 1'b1);
    waitIdle(100);
    tick();
    checkVal("one_tile_count", acc_byte.size(), 1);
    if (acc_col.size() > 0) checkVal("one_tile_col", acc_col[0], 3'd0);
    checkVal("one_tile_done", done_cnt, 1);
    checkVal("one_tile_err", err_cnt, 0);

    // Full eight-tile row with random latency and ready.
    fixed_lat = -1;
    rdy_pct = 60;
    clearLogs();
    startRead(6'd63, 3'd7);
    waitIdle(400);
    tick();
    checkVal("row8_tiles", acc_col.size(), 8);
    for (int i = 0; i < acc_col.size(); i++) begin
      checkVal("row8_col", acc_col[i], i);
    end
    checkVal("row8_fetches", sel_log.size(), 8);
    for (int i = 0; i < sel_log.size(); i++) begin
      checkVal("row8_sel_col", sel_log[i], i);
    end
    checkVal("row8_done", done_cnt, 1);

    // Randomized rows with stray strobes/starts, timeouts and resets.
    spurious = 1'b1;
    junk_pct = 5;
    for (int it = 0; it < 40; it++) begin
      rdy_pct    = int'($urandom_range(100, 20));
      mem_silent = ($urandom_range(7, 0) == 0);
      startRead(6'($urandom), 3'($urandom));
      if ($urandom_range(7, 0) == 0) begin
        repeat ($urandom_range(15, 0)) tick();
        assertReset();
        tick();
        I_RST_N = 1'b1;
      end else begin
        waitIdle(800);
        tick();
      end
    end
    mem_silent = 1'b0;
    spurious = 1'b0;
    junk_pct = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mat_tile_reader.md
MAT_TILE_READER -- requirements
Module: mat_tile_reader

Interface
REQ-001 I_CLK  input  1  single clock; all state changes on its rising edge.
REQ-002 I_RST_N  input  1  asynchronous, active-low reset.
REQ-003 I_START  input  1  one-cycle request to read a tile row; sampled only in IDLE.
REQ-004 I_LINE  input  6  tile line index to read; latched on accepted I_START.
REQ-005 I_LAST_COL  input  3  last tile column index (0..7); latched on accepted I_START.
REQ-006 O_ENA  output  1  memory-side enable toward the BRAM manager read port (WEA never driven; read-only).
REQ-007 O_SEL_LINE  output  6  memory-side line select.
REQ-008 O_SEL_COL  output  3  memory-side column select.
REQ-009 I_VLD  input  1  memory-side tile-valid strobe.
REQ-010 I_MAT  input  16x16x8  memory-side tile data, valid when I_VLD=1.
REQ-011 O_TILE  output  16x16x8  registered tile presented downstream.
REQ-012 O_TILE_VLD  output  1  O_TILE holds a tile not yet accepted.
REQ-013 I_TILE_RDY  input  1  downstream accept; transfer when O_TILE_VLD & I_TILE_RDY.
REQ-014 O_TILE_COL  output  3  column index of the tile in O_TILE.
REQ-015 O_BUSY  output  1  high in every state except IDLE.
REQ-016 O_DONE  output  1  one-cycle pulse after last tile accepted.
REQ-017 O_ERR  output  1  one-cycle pulse on memory timeout.

Function
REQ-018 States SHALL be IDLE, REQ, HOLD, DONE; encoding free.
REQ-019 IDLE: on I_START=1, latch I_LINE/I_LAST_COL, set column counter to 0, go to REQ; otherwise stay.
REQ-020 REQ: O_ENA=1, O_SEL_LINE=latched line, O_SEL_COL=column counter; held stable every cycle in REQ.
REQ-021 REQ: on edge where I_VLD=1, capture I_MAT into O_TILE, O_TILE_COL<=counter, O_TILE_VLD<=1, go to HOLD; O_ENA=0 from the next cycle.
REQ-022 I_VLD outside REQ SHALL be ignored; O_TILE unchanged.
REQ-023 Timeout: 4-bit wait counter cleared on REQ entry, +1 per REQ cycle without I_VLD; on reaching 15 with I_VLD=0, pulse O_ERR, clear O_TILE_VLD, go to IDLE (no O_DONE).
REQ-024 HOLD: O_ENA=0; O_TILE/O_TILE_COL stable; on I_TILE_RDY=1, O_TILE_VLD<=0 and, if counter==latched last col, go to DONE, else counter+1, go to REQ.
REQ-025 Minimum per-tile latency: REQ entry to O_TILE_VLD high = memory latency + 1 cycle; HOLD-to-REQ turnaround 1 cycle.
REQ-026 I_TILE_RDY=1 before O_TILE_VLD rises SHALL NOT accept anything.
REQ-027 DONE: O_DONE=1 for exactly that one cycle, then IDLE; I_START in DONE ignored.
REQ-028 I_START while O_BUSY=1 SHALL be ignored, latched parameters unchanged.
REQ-029 I_LAST_COL=0 SHALL read exactly one tile; I_LAST_COL=7 exactly eight, counter never wraps.

Reset
REQ-030 I_RST_N=0 at any time SHALL immediately force IDLE, O_ENA=0, O_SEL_LINE=0, O_SEL_COL=0, O_TILE all 0, O_TILE_COL=0, O_TILE_VLD=0, O_BUSY=0, O_DONE=0, O_ERR=0, counters 0.
REQ-031 Reset mid-transfer SHALL discard the pending tile; no O_DONE or O_ERR after release.
REQ-032 First I_START SHALL be honoured on the first rising edge after I_RST_N deasserts.

Verification
REQ-033 START line=2,last=3, memory returns 0x55/0x66/0x77/0x88 tiles, RDY=1 -> four tiles with O_TILE_COL 0..3 matching data, SEL_COL 0..3, then one O_DONE pulse.
REQ-034 RDY low 5 cycles in HOLD -> O_TILE and O_TILE_COL stable, O_ENA=0 throughout, next REQ one cycle after RDY rises.
REQ-035 I_VLD never asserted -> O_ERR pulse after 15 REQ cycles, O_BUSY falls, O_TILE_VLD=0, no O_DONE.
REQ-036 I_START during HOLD with line=9 -> ignored; remaining tiles still use original line.
REQ-037 I_RST_N low during REQ of column 1 -> all outputs zero asynchronously; new START line=1,last=0 -> single tile, O_DONE.
REQ-038 I_LAST_COL=7 -> exactly eight tiles, SEL_COL 0..7, counter does not wrap.
